core_fetch: RTL

Instruction fetch stage directly upstream of the decoder. Holds the PC and issues one outstanding request at a time to instruction memory. Presents the fetched word with its PC and a valid flag. Absorbs downstream stalls with a one-entry buffer and handles taken-branch/jump redirects, including squashing an in-flight response.

---
 rtl/core_fetch_if.sv | 15 +
 rtl/core_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_if.sv
// Instruction memory request/response bus between core_fetch (master) and
// instruction memory (slave).
//   IMEM_REQ   : request valid, level, held until IMEM_ACK
//   IMEM_ADDR  : request address, stable while IMEM_REQ=1 and no ACK yet
//   IMEM_ACK   : one-cycle response pulse, IMEM_RDATA valid in the same cycle
//   IMEM_RDATA : fetched word
interface core_fetch_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;

  modport master (output IMEM_REQ, output IMEM_ADDR, input IMEM_ACK, input IMEM_RDATA);
  modport slave  (input IMEM_REQ, input IMEM_ADDR, output IMEM_ACK, output IMEM_RDATA);
endinterface

// File: rtl/core_fetch.sv
// Instruction fetch stage feeding the decoder. Holds the PC, keeps at most one
// request outstanding to instruction memory, presents the fetched word with its
// PC, absorbs a downstream stall with a one-entry buffer and handles redirects,
// including squashing a response that was already in flight.
// Ports:
//   CLK, RST_N      : clock, synchronous active-low reset
//   imem            : instruction memory bus (master side)
//   STALL           : decoder cannot take INST this cycle
//   BRANCH_TAKEN/PC : redirect strobe and target from execute
//   INST/INST_PC    : instruction and its PC; INST is a NOP when INST_VALID=0
//   INST_VALID      : INST holds a real fetched instruction
//   MISALIGN_FAULT  : sticky, set by a redirect to a non-word-aligned target
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | just out of reset, launches the first request
// S_FETCH | request outstanding on the bus
// S_WAIT  | response parked in the buffer while the decoder stalls, no request
// S_FAULT | misaligned redirect seen; drains any outstanding request, then idle
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST_N,
  core_fetch_if.master       imem,
  input  logic               STALL,
  input  logic               BRANCH_TAKEN,
  input  logic [31:0]        BRANCH_PC,
  output logic [31:0]        INST,
  output logic [31:0]        INST_PC,
  output logic               INST_VALID,
  output logic               MISALIGN_FAULT
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_fault;
  logic        r_discard;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_addr;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_req_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_inst_pc_nxt;
  logic        w_inst_valid_nxt;
  logic        w_fault_nxt;
  logic        w_discard_nxt;
  logic [31:0] w_buf_data_nxt;
  logic [31:0] w_buf_addr_nxt;

  logic        w_redirect;
  logic        w_misalign;
  logic        w_ack;

  assign w_redirect = BRANCH_TAKEN && (BRANCH_PC[1:0] == 2'b00);
  assign w_misalign = BRANCH_TAKEN && (BRANCH_PC[1:0] != 2'b00);
  // An ACK only means something while a request is actually on the bus.
  assign w_ack      = imem.IMEM_ACK && r_req;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_inst       <= NOP;
      r_inst_pc    <= 32'h0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_discard    <= 1'b0;
      r_buf_data   <= 32'h0;
      r_buf_addr   <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_fault      <= w_fault_nxt;
      r_discard    <= w_discard_nxt;
      r_buf_data   <= w_buf_data_nxt;
      r_buf_addr   <= w_buf_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_nxt        = r_req;
    w_addr_nxt       = r_addr;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_valid_nxt = r_inst_valid;
    w_fault_nxt      = r_fault;
    w_discard_nxt    = r_discard;
    w_buf_data_nxt   = r_buf_data;
    w_buf_addr_nxt   = r_buf_addr;

    // Decoder took the current word; a load below overrides this.
    if (r_inst_valid && !STALL) begin
      w_inst_valid_nxt = 1'b0;
      w_inst_nxt       = NOP;
    end

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = r_pc;
        if (w_redirect) begin
          w_pc_nxt   = BRANCH_PC;
          w_addr_nxt = BRANCH_PC;
        end
      end

      S_FETCH: begin
        if (w_redirect) begin
          w_pc_nxt         = BRANCH_PC;
          w_inst_valid_nxt = 1'b0;
          w_inst_nxt       = NOP;
          if (w_ack) begin
            // The arriving word is the stale one; drop it and relaunch now.
            w_discard_nxt = 1'b0;
            w_addr_nxt    = BRANCH_PC;
          end else begin
            // Request must stay on the bus until its ACK, which is then dropped.
            // A repeated redirect lands here again and still drops just one.
            w_discard_nxt = 1'b1;
          end
        end else if (w_ack) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_addr_nxt    = r_pc;
          end else if (!r_inst_valid || !STALL) begin
            w_inst_nxt       = imem.IMEM_RDATA;
            w_inst_pc_nxt    = r_addr;
            w_inst_valid_nxt = 1'b1;
            w_pc_nxt         = r_addr + 32'd4;
            w_addr_nxt       = r_addr + 32'd4;
          end else begin
            w_buf_data_nxt = imem.IMEM_RDATA;
            w_buf_addr_nxt = r_addr;
            w_req_nxt      = 1'b0;
            w_state_nxt    = S_WAIT;
          end
        end
      end

      // The buffer is only meaningful in S_WAIT, so leaving it flushes it.
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt         = BRANCH_PC;
          w_inst_valid_nxt = 1'b0;
          w_inst_nxt       = NOP;
          w_state_nxt      = S_FETCH;
          w_req_nxt        = 1'b1;
          w_addr_nxt       = BRANCH_PC;
        end else if (!STALL) begin
          w_inst_nxt       = r_buf_data;
          w_inst_pc_nxt    = r_buf_addr;
          w_inst_valid_nxt = 1'b1;
          w_pc_nxt         = r_buf_addr + 32'd4;
          w_state_nxt      = S_FETCH;
          w_req_nxt        = 1'b1;
          w_addr_nxt       = r_buf_addr + 32'd4;
        end
      end

      S_FAULT: begin
        if (w_ack) begin
          w_req_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Misaligned redirect overrides everything; the fault state is absorbing.
    if (w_misalign && (r_state != S_FAULT)) begin
      w_fault_nxt      = 1'b1;
      w_state_nxt      = S_FAULT;
      w_inst_valid_nxt = 1'b0;
      w_inst_nxt       = NOP;
      w_discard_nxt    = 1'b0;
      w_req_nxt        = r_req && !w_ack;
      w_addr_nxt       = r_addr;
      w_pc_nxt         = r_pc;
    end
  end

  assign imem.IMEM_REQ  = r_req;
  assign imem.IMEM_ADDR = r_addr;
  assign INST           = r_inst;
  assign INST_PC        = r_inst_pc;
  assign INST_VALID     = r_inst_valid;
  assign MISALIGN_FAULT = r_fault;

endmodule
